keypad_decoder: RTL
===================

Name: keypad_decoder

Overview:
- Scans a 4x4 active-low key matrix, debounces presses, and classifies each key.
- Emits single-cycle events that feed the calculator control FSM's operator-received and equals-received inputs, and the operand datapath's digit input.
- Sits directly upstream of the control FSM. All outputs are registered in the core clock domain.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before advancing (minimum 2).
- DEBOUNCE_CYCLES, 20000: consecutive identical row samples required to accept a press or a release (minimum 1).
- REPEAT_CYCLES, 5000000: auto-repeat period; used only when the optional feature is compiled in.

Ports:
- clk  input  1  core clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- row_n  input  4  matrix rows, active-low, asynchronous to clk.
- col_n  output  4  matrix column drive, one-hot active-low.
- key_valid  output  1  one-cycle pulse for any accepted key.
- key_code  output  4  code of the last accepted key; held until the next accept.
- digit_valid  output  1  one-cycle pulse when the key is 0-9.
- digit  output  4  value 0-9; valid with digit_valid.
- op_recived  output  1  one-cycle pulse for + - * /.
- op_code  output  2  0=+, 1=-, 2=*, 3=/; held until the next operator.
- eq_recived  output  1  one-cycle pulse for =.
- clr_pulse  output  1  one-cycle pulse for clear.

Behaviour:
- row_n passes through a 2-flop synchronizer (reset value 4'hF). All checks below use the synchronized value rs.
- Reset values:
  - col_n=4'b1110, col_idx=0, state=SCAN, counters=0.
  - key_code=0, digit=0, op_code=0, all pulses 0.
- Key map, code = row*4+col lookup:
  - r0: 1,2,3,+ → codes 1,2,3,10
  - r1: 4,5,6,- → codes 4,5,6,11
  - r2: 7,8,9,* → codes 7,8,9,12
  - r3: clear,0,=,/ → codes 14,0,15,13
- Classification:
  - codes 0-9 → digit_valid
  - codes 10-13 → op_recived, with op_code=code-10
  - code 14 → clr_pulse
  - code 15 → eq_recived
  - key_valid accompanies every class.
- SCAN state:
  - A divider counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, if rs==4'hF: col_idx increments modulo 4 (3 wraps to 0) and col_n follows, taking effect on the next cycle.
  - At count SCAN_DIV-1, if rs!=4'hF: latch rs and col_idx, go to DEBOUNCE, keep the column driven, clear the debounce counter.
- DEBOUNCE state:
  - Each cycle, compare rs with the latched pattern.
  - Mismatch → return to SCAN; divider reset; same column.
  - Match → increment counter. When the counter reaches DEBOUNCE_CYCLES-1 → EMIT.
- EMIT state:
  - Lasts exactly 1 cycle.
  - key_code/digit/op_code update and the selected pulses are high in this cycle only.
  - Next state is WAIT_RELEASE.
- WAIT_RELEASE state:
  - Column held.
  - Counter counts consecutive cycles with rs==4'hF; any non-F value clears it.
  - At DEBOUNCE_CYCLES-1 → SCAN; divider reset; col_idx advances.
- Multiple rows low in one column: the lowest row index wins. The latched pattern is still the full rs, so any pattern change aborts debounce.
- Other-column keys pressed during WAIT_RELEASE are ignored because their column is not driven.
- At most one of digit_valid/op_recived/eq_recived/clr_pulse is high in any cycle.
- Minimum press-to-pulse latency: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the sample point.
- rst mid-operation: returns to reset values on the next edge; no pulse is emitted in that cycle.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: in WAIT_RELEASE, a digit key continuously held re-enters EMIT every REPEAT_CYCLES cycles.
  - The first repeat occurs REPEAT_CYCLES cycles after the first EMIT.
  - Non-digit keys never repeat.
  - The release counter runs independently of the repeat timer.
- Undefined: no repeat. REPEAT_CYCLES is unused and no repeat logic is synthesized.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=3, REPEAT_CYCLES=40):
- Reset, no keys → col_n cycles 1110,1101,1011,0111,1110, each held 4 cycles; all pulses 0.
- Hold r1/c1 ("5") stable → exactly one digit_valid+key_valid pulse, digit=5, key_code=5; no second pulse until release plus 3 idle cycles.
- Press r0/c3 ("+") then r3/c2 ("=") with releases between → op_recived with op_code=0, later eq_recived; key_code=10 then 15.
- Press "7" bouncing (rows toggle every 2 cycles for 10 cycles, then stable) → exactly one digit_valid, digit=7.
- Assert rst during DEBOUNCE of "9" → no pulse; col_n=1110 the cycle after reset; a later clean "9" still decodes with digit=9.
- KEYPAD_AUTOREPEAT_EN defined, hold "3" for 100 cycles after the first EMIT → repeats at +40 and +80 cycles (3 pulses total); holding "*" → exactly 1 pulse.

Source files
------------

// File: rtl/keypad_decoder.sv
// 4x4 active-low keypad scanner: column scan, debounce and key classification.
// Optional auto-repeat of held digit keys when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_decoder #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       digit_valid,
  output logic [3:0] digit,
  output logic       op_recived,
  output logic [1:0] op_code,
  output logic       eq_recived,
  output logic       clr_pulse,
  output logic [1:0] dbg_state
);

  if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("keypad_decoder: parameter out of range");
  end

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Code lookup indexed by {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'd1,  4'd2, 4'd3,  4'd10,
    4'd4,  4'd5, 4'd6,  4'd11,
    4'd7,  4'd8, 4'd9,  4'd12,
    4'd14, 4'd0, 4'd15, 4'd13
  };

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_EMIT         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  // All event outputs are one-cycle pulses with no backpressure: a consumer
  // must accept a pulse in the cycle it is high; codes hold until the next accept.

  state_t         state_q, state_d;
  logic [3:0]     sync1_q, rs_q;
  logic [1:0]     col_idx_q, col_idx_d;
  logic [3:0]     col_n_q, col_n_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]     lat_rows_q, lat_rows_d;
  logic [1:0]     lat_col_q, lat_col_d;
  logic [3:0]     key_code_q, key_code_d;
  logic [3:0]     digit_q, digit_d;
  logic [1:0]     op_code_q, op_code_d;
  logic           key_valid_q, key_valid_d;
  logic           digit_valid_q, digit_valid_d;
  logic           op_recived_q, op_recived_d;
  logic           eq_recived_q, eq_recived_d;
  logic           clr_pulse_q, clr_pulse_d;
  logic [3:0]     emit_code;
  logic           emit_now;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  // Repeat fires when the state machine moves into EMIT, one cycle before the pulse.
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 2);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // Lowest active row wins when several rows of one column are low.
  function automatic logic [3:0] key_lookup(input logic [3:0] rows_n, input logic [1:0] col);
    logic [1:0] row;
    casez (rows_n)
      4'b???0: row = 2'd0;
      4'b??01: row = 2'd1;
      4'b?011: row = 2'd2;
      default: row = 2'd3;
    endcase
    return KEY_MAP[{row, col}];
  endfunction

  assign emit_code = key_lookup(lat_rows_q, lat_col_q);

  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    div_d         = div_q;
    cnt_d         = cnt_q;
    lat_rows_d    = lat_rows_q;
    lat_col_d     = lat_col_q;
    key_code_d    = key_code_q;
    digit_d       = digit_q;
    op_code_d     = op_code_q;
    key_valid_d   = 1'b0;
    digit_valid_d = 1'b0;
    op_recived_d  = 1'b0;
    eq_recived_d  = 1'b0;
    clr_pulse_d   = 1'b0;
    emit_now      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d         = rep_q;
`endif

    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rs_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            lat_rows_d = rs_q;
            lat_col_d  = col_idx_q;
            cnt_d      = '0;
            state_d    = ST_DEBOUNCE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (rs_q != lat_rows_q) begin
          state_d = ST_SCAN;
          div_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          emit_now = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_EMIT: begin
        state_d = ST_WAIT_RELEASE;
        cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = '0;
`endif
      end

      default: begin
        if (rs_q == 4'hF) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_SCAN;
            div_d     = '0;
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat timer runs only while the exact latched pattern stays held.
        if (rs_q == lat_rows_q && emit_code <= 4'd9) begin
          if (rep_q == REP_LAST) begin
            emit_now = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          rep_d = '0;
        end
`endif
      end
    endcase

    if (emit_now) begin
      state_d     = ST_EMIT;
      key_valid_d = 1'b1;
      key_code_d  = emit_code;
      if (emit_code <= 4'd9) begin
        digit_valid_d = 1'b1;
        digit_d       = emit_code;
      end else if (emit_code <= 4'd13) begin
        op_recived_d = 1'b1;
        op_code_d    = 2'(emit_code - 4'd10);
      end else if (emit_code == 4'd14) begin
        clr_pulse_d = 1'b1;
      end else begin
        eq_recived_d = 1'b1;
      end
    end

    col_n_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 4'hF;
      rs_q          <= 4'hF;
      state_q       <= ST_SCAN;
      col_idx_q     <= 2'd0;
      col_n_q       <= 4'b1110;
      div_q         <= '0;
      cnt_q         <= '0;
      lat_rows_q    <= 4'hF;
      lat_col_q     <= 2'd0;
      key_code_q    <= 4'd0;
      digit_q       <= 4'd0;
      op_code_q     <= 2'd0;
      key_valid_q   <= 1'b0;
      digit_valid_q <= 1'b0;
      op_recived_q  <= 1'b0;
      eq_recived_q  <= 1'b0;
      clr_pulse_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q         <= '0;
`endif
    end else begin
      sync1_q       <= row_n;
      rs_q          <= sync1_q;
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      col_n_q       <= col_n_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      lat_rows_q    <= lat_rows_d;
      lat_col_q     <= lat_col_d;
      key_code_q    <= key_code_d;
      digit_q       <= digit_d;
      op_code_q     <= op_code_d;
      key_valid_q   <= key_valid_d;
      digit_valid_q <= digit_valid_d;
      op_recived_q  <= op_recived_d;
      eq_recived_q  <= eq_recived_d;
      clr_pulse_q   <= clr_pulse_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q         <= rep_d;
`endif
    end
  end

  assign col_n       = col_n_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign digit_valid = digit_valid_q;
  assign digit       = digit_q;
  assign op_recived  = op_recived_q;
  assign op_code     = op_code_q;
  assign eq_recived  = eq_recived_q;
  assign clr_pulse   = clr_pulse_q;
  assign dbg_state   = state_q;

endmodule
